// File: rtl/stream_residual_packer.sv
// Block packer: collects NUM_PIX pixels, then emits either a min/bits-required header
// with per-pixel residuals in one line (flag 01) or the raw block across two lines (flag 00).
module stream_residual_packer #(
    parameter int NUM_PIX = 32,
    parameter int NUM_CH  = 4,
    parameter int CH_W    = 8,
    parameter int LINE_W  = 512,
    parameter int BR_W    = 3,
    parameter int HDR_W   = 48
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NUM_CH*CH_W-1:0]   in_pixel,
    input  logic                     force_raw,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [2*LINE_W-1:0]      lines,
    output logic [1:0]               flag
);

    localparam int PIX_W  = NUM_CH * CH_W;
    localparam int CNT_W  = (NUM_PIX > 1) ? $clog2(NUM_PIX) : 1;
    localparam int BR_MAX = (1 << BR_W) - 1;
    localparam int BRF_W  = $clog2(CH_W + 1);
    localparam int PK_W   = NUM_CH * BR_MAX;
    localparam int POS_W  = $clog2(LINE_W + 1);

    localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(NUM_PIX - 1);

    localparam logic [1:0] COLLECT = 2'd0;
    localparam logic [1:0] EVAL    = 2'd1;
    localparam logic [1:0] PACK    = 2'd2;
    localparam logic [1:0] OUT     = 2'd3;

    if (NUM_PIX * NUM_CH * CH_W != 2 * LINE_W) begin : g_bad_block_size
        $error("stream_residual_packer: NUM_PIX*NUM_CH*CH_W must equal 2*LINE_W");
    end
    if (HDR_W < NUM_CH * (CH_W + BR_W)) begin : g_bad_hdr_size
        $error("stream_residual_packer: HDR_W too small for min and bits-required fields");
    end

    logic [1:0]          state;
    logic [CNT_W-1:0]    cnt;
    logic [PIX_W-1:0]    buffer [NUM_PIX];
    logic [CH_W-1:0]     min_q  [NUM_CH];
    logic [CH_W-1:0]     max_q  [NUM_CH];
    logic [BR_W-1:0]     br_q   [NUM_CH];
    logic                raw_q;
    logic [POS_W-1:0]    sum_q;
    logic [POS_W-1:0]    shamt_q;
    logic [2*LINE_W-1:0] lines_q;
    logic [1:0]          flag_q;
    logic                valid_q;

    logic [CH_W-1:0]     rng_c  [NUM_CH];
    logic [BRF_W-1:0]    br_c   [NUM_CH];
    logic [CH_W-1:0]     res_c  [NUM_CH];
    logic [31:0]         sum_c;
    logic                over_c;
    logic                go_raw;
    logic [HDR_W-1:0]    hdr;
    logic [2*LINE_W-1:0] raw_line;
    logic [PIX_W-1:0]    cur_pix;
    logic [PK_W-1:0]     packed_bits;
    logic [LINE_W-1:0]   ext;
    logic                accept;

    assign in_ready  = rst & (state == COLLECT);
    assign accept    = in_valid & in_ready;
    assign out_valid = valid_q;
    assign lines     = lines_q;
    assign flag      = flag_q;

    // Range, bits-required and header from the running min/max of the finished block.
    always_comb begin
        over_c = 1'b0;
        sum_c  = '0;
        hdr    = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            rng_c[c] = max_q[c] - min_q[c];
            br_c[c]  = '0;
            for (int unsigned b = 0; b < CH_W; b++) begin
                if (rng_c[c][b]) begin
                    br_c[c] = BRF_W'(b + 1);
                end
            end
            if (32'(br_c[c]) > 32'(BR_MAX)) begin
                over_c = 1'b1;
            end
            sum_c = sum_c + 32'(br_c[c]);
            hdr[HDR_W-1-c*CH_W -: CH_W] = min_q[c];
            hdr[HDR_W-1-NUM_CH*CH_W-c*BR_W -: BR_W] = BR_W'(br_c[c]);
        end
        go_raw = raw_q | over_c | ((32'(HDR_W) + 32'(NUM_PIX) * sum_c) > 32'(LINE_W));
    end

    always_comb begin
        raw_line = '0;
        for (int unsigned i = 0; i < NUM_PIX; i++) begin
            raw_line[2*LINE_W-1-i*PIX_W -: PIX_W] = buffer[i];
        end
    end

    // Residuals of one pixel concatenated MSB-first; zero-width channels shift by 0.
    always_comb begin
        cur_pix     = buffer[cnt];
        packed_bits = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            res_c[c]    = cur_pix[PIX_W-1-c*CH_W -: CH_W] - min_q[c];
            packed_bits = (packed_bits << br_q[c]) | PK_W'(res_c[c]);
        end
        ext = LINE_W'(packed_bits);
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            buffer[cnt] <= in_pixel;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= COLLECT;
            cnt     <= '0;
            raw_q   <= 1'b0;
            sum_q   <= '0;
            shamt_q <= '0;
            lines_q <= '0;
            flag_q  <= 2'b00;
            valid_q <= 1'b0;
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                min_q[c] <= '1;
                max_q[c] <= '0;
                br_q[c]  <= '0;
            end
        end else begin
            case (state)
                COLLECT: begin
                    if (accept) begin
                        if (cnt == '0) begin
                            raw_q <= force_raw;
                        end
                        for (int unsigned c = 0; c < NUM_CH; c++) begin
                            if (in_pixel[PIX_W-1-c*CH_W -: CH_W] < min_q[c]) begin
                                min_q[c] <= in_pixel[PIX_W-1-c*CH_W -: CH_W];
                            end
                            if (in_pixel[PIX_W-1-c*CH_W -: CH_W] > max_q[c]) begin
                                max_q[c] <= in_pixel[PIX_W-1-c*CH_W -: CH_W];
                            end
                        end
                        if (cnt == LAST_PIX) begin
                            cnt   <= '0;
                            state <= EVAL;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                EVAL: begin
                    for (int unsigned c = 0; c < NUM_CH; c++) begin
                        br_q[c] <= BR_W'(br_c[c]);
                    end
                    sum_q   <= POS_W'(sum_c);
                    shamt_q <= POS_W'(LINE_W - HDR_W) - POS_W'(sum_c);
                    if (go_raw) begin
                        lines_q <= raw_line;
                        flag_q  <= 2'b00;
                        valid_q <= 1'b1;
                        state   <= OUT;
                    end else begin
                        lines_q <= {hdr, {(2*LINE_W-HDR_W){1'b0}}};
                        state   <= PACK;
                    end
                end
                PACK: begin
                    // shamt_q is the LSB offset of this pixel's field inside line 0.
                    lines_q <= lines_q | {ext << shamt_q, {LINE_W{1'b0}}};
                    shamt_q <= shamt_q - sum_q;
                    if (cnt == LAST_PIX) begin
                        cnt     <= '0;
                        flag_q  <= 2'b01;
                        valid_q <= 1'b1;
                        state   <= OUT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        valid_q <= 1'b0;
                        cnt     <= '0;
                        state   <= COLLECT;
                        for (int unsigned c = 0; c < NUM_CH; c++) begin
                            min_q[c] <= '1;
                            max_q[c] <= '0;
                        end
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end

endmodule

// File: tb/tb_stream_residual_packer.sv
// Directed bench for stream_residual_packer: compressed, raw, backpressure and
// asynchronous-reset scenarios with hand-derived expected lines.
module tb_stream_residual_packer;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   in_pixel;
    logic          force_raw;
    logic          out_valid;
    logic          out_ready;
    logic [1023:0] lines;
    logic [1:0]    flag;

    int            checks = 0;
    int            errors = 0;
    logic [31:0]   pix [32];
    logic [1023:0] exp_l;
    int            lat;

    always #5 clk = ~clk;

    stream_residual_packer #(
        .NUM_PIX(32), .NUM_CH(4), .CH_W(8), .LINE_W(512), .BR_W(3), .HDR_W(48)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_pixel(in_pixel), .force_raw(force_raw), .out_valid(out_valid),
        .out_ready(out_ready), .lines(lines), .flag(flag)
    );

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic feed(input logic fr);
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            in_valid  = 1'b1;
            in_pixel  = pix[i];
            force_raw = (i == 0) ? fr : 1'b0;
            @(posedge clk);
        end
        #1;
        in_valid  = 1'b0;
        force_raw = 1'b0;
    endtask

    task automatic wait_out(output int l);
        bit seen = 1'b0;
        l = 0;
        while (!seen && l < 100) begin
            @(posedge clk);
            #1;
            l++;
            seen = out_valid;
        end
    endtask

    task automatic check_block(input string tag, input logic [1:0] ef,
                               input logic [1023:0] el, input int elat);
        wait_out(lat);
        chk({tag, ".latency"}, 512'(lat), 512'(elat));
        chk({tag, ".out_valid"}, 512'(out_valid), 512'(1'b1));
        chk({tag, ".flag"}, 512'(flag), 512'(ef));
        chk({tag, ".line0"}, lines[1023:512], el[1023:512]);
        chk({tag, ".line1"}, lines[511:0], el[511:0]);
    endtask

    task automatic drain(input string tag);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk({tag, ".drain_valid"}, 512'(out_valid), 512'(1'b0));
        chk({tag, ".drain_ready"}, 512'(in_ready), 512'(1'b1));
        out_ready = 1'b0;
    endtask

    task automatic build_raw();
        exp_l = '0;
        for (int i = 0; i < 32; i++) begin
            exp_l[1023-32*i -: 32] = pix[i];
        end
    endtask

    task automatic fill_uniform(input logic [31:0] v);
        for (int i = 0; i < 32; i++) begin
            pix[i] = v;
        end
    endtask

    initial begin
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_pixel  = '0;
        force_raw = 1'b0;
        out_ready = 1'b0;

        #12;
        chk("reset.out_valid", 512'(out_valid), 512'(1'b0));
        chk("reset.in_ready", 512'(in_ready), 512'(1'b0));
        chk("reset.flag", 512'(flag), 512'(2'b00));
        chk("reset.line0", lines[1023:512], 512'(0));
        chk("reset.line1", lines[511:0], 512'(0));
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("reset.in_ready_after", 512'(in_ready), 512'(1'b1));

        // Uniform block: all br=0, header only.
        fill_uniform(32'h0A141EFF);
        feed(1'b0);
        exp_l = {48'h0A141EFF0000, 976'b0};
        check_block("uniform", 2'b01, exp_l, 33);
        drain("uniform");

        // Ramp on r: br_r=5, residual i in 5-bit fields below the header.
        for (int i = 0; i < 32; i++) begin
            pix[i] = {8'(i), 24'h070707};
        end
        feed(1'b0);
        exp_l = {48'h00070707A000, 976'b0};
        for (int i = 0; i < 32; i++) begin
            exp_l[975-5*i -: 5] = 5'(i);
        end
        check_block("ramp", 2'b01, exp_l, 33);
        drain("ramp");

        // r alternating 0/200 needs 8 bits, beyond the 3-bit header field.
        for (int i = 0; i < 32; i++) begin
            pix[i] = {((i % 2) == 1) ? 8'd200 : 8'd0, 8'(i), 8'h55, 8'h80};
        end
        feed(1'b0);
        build_raw();
        check_block("wide", 2'b00, exp_l, 1);
        drain("wide");

        // br=4 on every channel: 48 + 32*16 = 560 bits does not fit.
        for (int i = 0; i < 32; i++) begin
            pix[i] = {4{8'(i % 16)}};
        end
        feed(1'b0);
        build_raw();
        check_block("overflow", 2'b00, exp_l, 1);
        drain("overflow");

        // Uniform data forced raw, then held in OUT under backpressure.
        fill_uniform(32'h0A141EFF);
        feed(1'b1);
        build_raw();
        check_block("force_raw", 2'b00, exp_l, 1);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            in_valid  = 1'b1;
            in_pixel  = 32'hDEADBEEF;
            out_ready = 1'b0;
            @(posedge clk);
            #1;
            chk("bp.out_valid", 512'(out_valid), 512'(1'b1));
            chk("bp.in_ready", 512'(in_ready), 512'(1'b0));
            chk("bp.flag", 512'(flag), 512'(2'b00));
            chk("bp.line0", lines[1023:512], exp_l[1023:512]);
            chk("bp.line1", lines[511:0], exp_l[511:0]);
        end
        drain("bp");

        // Next block after backpressure must be unaffected by the ignored beats.
        fill_uniform(32'h0A141EFF);
        feed(1'b0);
        exp_l = {48'h0A141EFF0000, 976'b0};
        check_block("after_bp", 2'b01, exp_l, 33);
        drain("after_bp");

        // Abort during PACK pixel 10 with an asynchronous reset.
        feed(1'b0);
        repeat (11) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("abort.out_valid", 512'(out_valid), 512'(1'b0));
        chk("abort.in_ready", 512'(in_ready), 512'(1'b0));
        chk("abort.flag", 512'(flag), 512'(2'b00));
        chk("abort.line0", lines[1023:512], 512'(0));
        chk("abort.line1", lines[511:0], 512'(0));
        repeat (2) @(negedge clk);
        rst = 1'b1;

        feed(1'b0);
        exp_l = {48'h0A141EFF0000, 976'b0};
        check_block("post_reset", 2'b01, exp_l, 33);
        drain("post_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
